// File: rtl/dmem_wb_master.sv
// Data-side Wishbone B4 classic master for the rv32i memory stage: one bus cycle per
// load/store, lane steering, load extension, pipeline stall and error/misalignment pulses.
module dmem_wb_master #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_RDATA      = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] mem_addr_mem,
  input  logic [31:0] mem_wdata_mem,
  input  logic        mem_write_mem,
  input  logic        mem_read_mem,
  input  logic [2:0]  mem_op_mem,
  output logic [31:0] mem_rdata_mem,
  output logic        stall_pipl,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  output logic        bus_err_o,
  output logic        misaligned_o
);

  typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

  localparam int unsigned     CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic            TO_EN    = (TIMEOUT_CYCLES != 0);

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  // Access size from funct3; anything that is not a byte or half op behaves as a word.
  function automatic logic [1:0] op_size(input logic [2:0] op);
    case (op)
      3'b000, 3'b100: op_size = SZ_B;
      3'b001, 3'b101: op_size = SZ_H;
      default:        op_size = SZ_W;
    endcase
  endfunction

  function automatic logic [3:0] lane_sel(input logic [1:0] sz, input logic [1:0] lane);
    case (sz)
      SZ_B:    lane_sel = 4'b0001 << lane;
      SZ_H:    lane_sel = 4'b0011 << lane;
      default: lane_sel = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_dat(input logic [1:0] sz, input logic [31:0] wd);
    case (sz)
      SZ_B:    lane_dat = {4{wd[7:0]}};
      SZ_H:    lane_dat = {2{wd[15:0]}};
      default: lane_dat = wd;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] lane);
    case (sz)
      SZ_B:    is_misaligned = 1'b0;
      SZ_H:    is_misaligned = lane[0];
      default: is_misaligned = (lane != 2'b00);
    endcase
  endfunction

  function automatic logic [31:0] load_ext(input logic [2:0] op, input logic [1:0] lane,
                                           input logic [31:0] rd);
    logic [31:0] b_sh;
    logic [31:0] h_sh;
    b_sh = rd >> {lane, 3'b000};
    h_sh = rd >> {lane[1], 4'b0000};
    case (op)
      3'b000:  load_ext = {{24{b_sh[7]}}, b_sh[7:0]};
      3'b100:  load_ext = {24'h000000, b_sh[7:0]};
      3'b001:  load_ext = {{16{h_sh[15]}}, h_sh[15:0]};
      3'b101:  load_ext = {16'h0000, h_sh[15:0]};
      default: load_ext = rd;
    endcase
  endfunction

  state_t            state_q;
  logic              cyc_q;
  logic              we_q;
  logic [31:0]       adr_q;
  logic [31:0]       dat_q;
  logic [3:0]        sel_q;
  logic [2:0]        op_q;
  logic [1:0]        lane_q;
  logic              load_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [31:0]       rdata_q;
  logic              berr_q;
  logic              mis_q;

  logic              req;
  logic [1:0]        req_sz;
  logic              req_mis;
  logic              timeout;

  assign req     = mem_read_mem | mem_write_mem;
  assign req_sz  = op_size(mem_op_mem);
  assign req_mis = is_misaligned(req_sz, mem_addr_mem[1:0]);
  assign timeout = TO_EN && (cnt_q == CNT_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
      sel_q   <= '0;
      op_q    <= '0;
      lane_q  <= '0;
      load_q  <= 1'b0;
      cnt_q   <= '0;
      rdata_q <= '0;
      berr_q  <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      berr_q <= 1'b0;
      mis_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req) begin
            op_q   <= mem_op_mem;
            lane_q <= mem_addr_mem[1:0];
            load_q <= ~mem_write_mem;
            if (req_mis) begin
              // Misaligned requests never reach the bus; only loads see the error value.
              mis_q   <= 1'b1;
              if (!mem_write_mem) rdata_q <= ERR_RDATA;
              state_q <= DONE;
            end else begin
              cyc_q   <= 1'b1;
              we_q    <= mem_write_mem;
              adr_q   <= {mem_addr_mem[31:2], 2'b00};
              dat_q   <= lane_dat(req_sz, mem_wdata_mem);
              sel_q   <= lane_sel(req_sz, mem_addr_mem[1:0]);
              cnt_q   <= '0;
              state_q <= BUS;
            end
          end
        end
        BUS: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (wb_err_i || timeout) begin
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
            berr_q  <= 1'b1;
            if (load_q) rdata_q <= ERR_RDATA;
            state_q <= DONE;
          end else if (wb_ack_i) begin
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
            if (load_q) rdata_q <= load_ext(op_q, lane_q, wb_dat_i);
            state_q <= DONE;
          end
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Stall is combinational in IDLE so the request is frozen in the same cycle it appears.
  assign stall_pipl    = ((state_q == IDLE) && req) || (state_q == BUS);
  assign wb_cyc_o      = cyc_q;
  assign wb_stb_o      = cyc_q;
  assign wb_we_o       = we_q;
  assign wb_adr_o      = adr_q;
  assign wb_dat_o      = dat_q;
  assign wb_sel_o      = sel_q;
  assign mem_rdata_mem = rdata_q;
  assign bus_err_o     = berr_q;
  assign misaligned_o  = mis_q;

endmodule

// File: doc/dmem_wb_master.md
Name: dmem_wb_master

Overview:
- Data-side bus master sitting directly downstream of the rv32i core's memory stage.
- Converts the core's mem-stage request (address, write data, op, read/write strobes) into a single Wishbone B4 classic cycle.
- Generates byte selects, aligns and sign/zero-extends load data, and drives stall_pipl back into the core until the transfer completes.
- Reports bus errors, timeouts and misaligned accesses as one-cycle pulses.

Parameters:
- TIMEOUT_CYCLES, 255: bus cycles allowed without ack/err before abort; 0 disables the timeout.
- ERR_RDATA, 32'h0000_0000: load value returned on error, timeout or misalignment.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- mem_addr_mem  in  32  byte address from mem stage
- mem_wdata_mem  in  32  store data, unshifted, in low bits
- mem_write_mem  in  1  store request
- mem_read_mem  in  1  load request
- mem_op_mem  in  3  funct3: 000 b, 001 h, 010 w, 100 bu, 101 hu
- mem_rdata_mem  out  32  aligned and extended load result
- stall_pipl  out  1  freeze pipeline while transfer is pending
- wb_cyc_o  out  1  Wishbone cycle
- wb_stb_o  out  1  Wishbone strobe
- wb_we_o  out  1  write enable
- wb_adr_o  out  32  word address: {addr[31:2], 2'b00}
- wb_dat_o  out  32  lane-shifted store data
- wb_sel_o  out  4  byte lane selects
- wb_dat_i  in  32  read data
- wb_ack_i  in  1  acknowledge
- wb_err_i  in  1  bus error
- bus_err_o  out  1  one-cycle pulse on err or timeout
- misaligned_o  out  1  one-cycle pulse on a misaligned request

Behaviour:
Reset:
- state IDLE; wb_cyc_o, wb_stb_o and wb_we_o all 0.
- wb_adr_o, wb_dat_o, wb_sel_o all 0.
- mem_rdata_mem 0; stall_pipl 0; both pulse outputs 0; timeout counter 0.
- Reset mid-transfer drops cyc/stb at that edge. There is no wait for ack, and a late ack is ignored.

Request:
- req = mem_read_mem | mem_write_mem.
- mem_write_mem has priority if both are high; it is treated as a store.
- The core holds all mem_* inputs stable while stall_pipl=1.

FSM states: IDLE, BUS, DONE.
- IDLE, req=0: stall_pipl=0.
- IDLE, req=1, aligned: stall_pipl=1 (combinational). Next edge: register adr/dat/sel/we, assert cyc=stb=1, go to BUS.
- IDLE, req=1, misaligned (h with addr[0]=1, w with addr[1:0]!=0): stall_pipl=1. Next edge: misaligned_o=1 for one cycle, no bus cycle, load result = ERR_RDATA, go to DONE.
- BUS: stall_pipl=1; counter increments every cycle.
- BUS, ack=1: latch the aligned load result, drop cyc/stb, go to DONE.
- BUS, err=1 (err has priority over ack in the same cycle): drop cyc/stb, bus_err_o pulse, result = ERR_RDATA, go to DONE.
- BUS, counter reaches TIMEOUT_CYCLES: same handling as err.
- DONE: stall_pipl=0 and mem_rdata_mem holds the latched result; the pipeline advances at this edge.
- DONE next edge: go to IDLE unconditionally. No new request is sampled in DONE, so the completed instruction is never re-issued.
- Back-to-back accesses therefore take at least 3 cycles each.

Latency:
- Zero-wait-state slave (ack in the first BUS cycle): stall high for 2 cycles, then the DONE cycle.

Lanes:
- Byte: sel = 1 << addr[1:0]; dat = {4{wdata[7:0]}}.
- Half: sel = 4'b0011 << addr[1:0]; dat = {2{wdata[15:0]}}.
- Word: sel = 4'b1111; dat = wdata.
- Loads use the same sel pattern.

Load extension:
- Select the byte or half at the addressed lane.
- op 000/001: sign-extend; op 100/101: zero-extend; op 010: pass through.
- Undefined mem_op values are treated as word.

mem_rdata_mem:
- Retains the last result outside DONE.
- Updated only when a load completes.
- Store completions leave it unchanged.

Test Plan:
1. lw addr 0x104, slave acks on the first BUS cycle with 0xCAFEBABE -> sel=1111, adr=0x104, stall high 2 cycles, mem_rdata_mem=0xCAFEBABE in the DONE cycle.
2. lb addr 0x103 with wb_dat_i=0x80112233 -> sel=1000, mem_rdata_mem=0xFFFFFF80. lbu at the same address -> 0x00000080.
3. sh addr 0x202 with wdata 0x0000ABCD -> we=1, sel=1100, dat=0xABCDABCD, adr=0x200. mem_rdata_mem is unchanged.
4. lw to 0x300 where the slave never acks, TIMEOUT_CYCLES=4 -> cyc drops after 4 BUS cycles, bus_err_o pulses once, result=ERR_RDATA, stall released.
5. lh addr 0x101 -> no cyc asserted, misaligned_o pulses, stall high 1 cycle, then DONE with result=ERR_RDATA.
6. Two back-to-back lw (0x10, 0x14) with 2-wait-state acks, plus reset asserted during the BUS phase of the second -> two distinct bus cycles for the first pair with no re-issue. After the reset edge: cyc=0, stall=0, all outputs at reset values, and the late ack is ignored.
